// File: rtl/escalonador_pedidos_if.sv
// escalonador_pedidos_if: request/leg bus between request logic, scheduler and uc_movimento
interface escalonador_pedidos_if #(
    parameter int W     = 2,
    parameter int DEPTH = 4
);
    logic                    limpar;
    logic                    novo_pedido;
    logic [W-1:0]            pedido_origem;
    logic [W-1:0]            pedido_destino;
    logic [W-1:0]            andar_atual;
    logic                    shift;
    logic                    tem_destino;
    logic [W-1:0]            destino_atual;
    logic                    eh_origem;
    logic                    sobe;
    logic                    chegou_destino;
    logic                    atende_local;
    logic                    pedido_rejeitado;
    logic                    cheia;
    logic                    vazia;
    logic [$clog2(DEPTH):0]  ocupacao;

    modport master (
        output limpar, novo_pedido, pedido_origem, pedido_destino, andar_atual, shift,
        input  tem_destino, destino_atual, eh_origem, sobe, chegou_destino, atende_local,
               pedido_rejeitado, cheia, vazia, ocupacao
    );

    modport slave (
        input  limpar, novo_pedido, pedido_origem, pedido_destino, andar_atual, shift,
        output tem_destino, destino_atual, eh_origem, sobe, chegou_destino, atende_local,
               pedido_rejeitado, cheia, vazia, ocupacao
    );
endinterface

// File: rtl/escalonador_pedidos.sv
// escalonador_pedidos: queues origem->destino requests and serves them one leg at a time
module escalonador_pedidos #(
    parameter int N_ANDARES = 4,
    parameter int W         = 2,
    parameter int DEPTH     = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    escalonador_pedidos_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {OCIOSO, CARREGA_ORIG, CARREGA_DEST, SERVE} estado_t;

    estado_t          r_state;
    estado_t          w_next;
    logic [2*W-1:0]   r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_count;
    logic [W-1:0]     r_destino;
    logic             r_eh_origem;
    logic             r_atende;
    logic             r_rejeitado;
    logic [W-1:0]     w_head_orig;
    logic [W-1:0]     w_head_dest;
    logic             w_cheia;
    logic             w_vazia;
    logic             w_valido;
    logic             w_push;
    logic             w_pop;
    logic             w_load_orig;
    logic             w_load_dest;
    logic             w_local;
    logic             w_tem;

    assign {w_head_orig, w_head_dest} = r_mem[r_rd];
    assign w_cheia  = r_count == (AW+1)'(DEPTH);
    assign w_vazia  = r_count == '0;
    assign w_valido = (bus.pedido_origem != bus.pedido_destino)
                   && (32'(bus.pedido_origem) < 32'(N_ANDARES))
                   && (32'(bus.pedido_destino) < 32'(N_ANDARES));
    // a full FIFO still accepts a request when the head leaves in the same cycle
    assign w_push   = bus.novo_pedido && !bus.limpar && w_valido && (!w_cheia || w_pop);
    assign w_tem    = r_state == SERVE;

    // leg sequencing: the head is only popped once its destino leg completes
    always_comb begin
        w_next      = r_state;
        w_pop       = 1'b0;
        w_load_orig = 1'b0;
        w_load_dest = 1'b0;
        w_local     = 1'b0;
        if (bus.limpar) begin
            w_next = OCIOSO;
        end else begin
            case (r_state)
                OCIOSO:       w_next = w_vazia ? OCIOSO : CARREGA_ORIG;
                CARREGA_ORIG: begin
                    w_load_orig = 1'b1;
                    w_local     = w_head_orig == bus.andar_atual;
                    w_next      = w_local ? CARREGA_DEST : SERVE;
                end
                CARREGA_DEST: begin
                    w_load_dest = 1'b1;
                    w_local     = w_head_dest == bus.andar_atual;
                    w_pop       = w_local;
                    w_next      = w_local ? OCIOSO : SERVE;
                end
                default: if (bus.shift) begin
                    w_pop  = !r_eh_origem;
                    w_next = r_eh_origem ? CARREGA_DEST : OCIOSO;
                end
            endcase
        end
    end

    // state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= OCIOSO;
        else          r_state <= w_next;
    end

    // FIFO pointers and occupancy; limpar discards everything queued
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (bus.limpar) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            r_wr    <= w_push ? r_wr + AW'(1) : r_wr;
            r_rd    <= w_pop ? r_rd + AW'(1) : r_rd;
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    // FIFO storage needs no reset: contents are qualified by occupancy
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr] <= {bus.pedido_origem, bus.pedido_destino};
    end

    // current leg registers and one-cycle status pulses
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_destino   <= '0;
            r_eh_origem <= 1'b0;
            r_atende    <= 1'b0;
            r_rejeitado <= 1'b0;
        end else begin
            r_destino   <= w_load_orig ? w_head_orig : w_load_dest ? w_head_dest : bus.limpar ? '0 : r_destino;
            r_eh_origem <= w_load_orig ? 1'b1 : (w_load_dest || bus.limpar) ? 1'b0 : r_eh_origem;
            r_atende    <= w_local;
            r_rejeitado <= bus.novo_pedido && !bus.limpar && !w_push;
        end
    end

    assign bus.tem_destino      = w_tem;
    assign bus.destino_atual    = r_destino;
    assign bus.eh_origem        = r_eh_origem;
    assign bus.sobe             = w_tem && (r_destino > bus.andar_atual);
    assign bus.chegou_destino   = w_tem && (r_destino == bus.andar_atual);
    assign bus.atende_local     = r_atende;
    assign bus.pedido_rejeitado = r_rejeitado;
    assign bus.cheia            = w_cheia;
    assign bus.vazia            = w_vazia;
    assign bus.ocupacao         = r_count;
endmodule

// File: tb/tb_escalonador_pedidos.sv
// tb_escalonador_pedidos: directed self-checking bench for the request scheduler
module tb_escalonador_pedidos;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    escalonador_pedidos_if #(.W(3), .DEPTH(4)) bus ();

    escalonador_pedidos #(.N_ANDARES(4), .W(3), .DEPTH(4)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pedido(input logic [2:0] o, input logic [2:0] d);
        bus.novo_pedido    = 1'b1;
        bus.pedido_origem  = o;
        bus.pedido_destino = d;
        tick();
        bus.novo_pedido    = 1'b0;
    endtask

    initial begin
        bus.limpar = 0; bus.novo_pedido = 0; bus.pedido_origem = 0;
        bus.pedido_destino = 0; bus.andar_atual = 0; bus.shift = 0;
        tick(); tick();
        chk("rst_vazia", bus.vazia, 1);
        chk("rst_tem", bus.tem_destino, 0);
        chk("rst_ocup", bus.ocupacao, 0);
        chk("rst_cheia", bus.cheia, 0);
        chk("rst_dest", bus.destino_atual, 0);
        chk("rst_rej", bus.pedido_rejeitado, 0);
        rst_n = 1'b1;
        tick();
        // pickup 1 -> delivery 3 starting on floor 0
        pedido(1, 3);
        chk("t1_ocup", bus.ocupacao, 1);
        chk("t1_tem_k", bus.tem_destino, 0);
        tick();
        chk("t1_tem_k1", bus.tem_destino, 0);
        tick();
        chk("t1_tem", bus.tem_destino, 1);
        chk("t1_dest", bus.destino_atual, 1);
        chk("t1_eh", bus.eh_origem, 1);
        chk("t1_sobe", bus.sobe, 1);
        chk("t1_chegou0", bus.chegou_destino, 0);
        bus.andar_atual = 1;
        #1;
        chk("t2_chegou_orig", bus.chegou_destino, 1);
        bus.shift = 1;
        tick();
        bus.shift = 0;
        chk("t2_tem_carrega", bus.tem_destino, 0);
        tick();
        chk("t2_tem", bus.tem_destino, 1);
        chk("t2_dest", bus.destino_atual, 3);
        chk("t2_eh", bus.eh_origem, 0);
        chk("t2_sobe", bus.sobe, 1);
        chk("t2_ocup", bus.ocupacao, 1);
        bus.andar_atual = 3;
        #1;
        chk("t2_chegou_dest", bus.chegou_destino, 1);
        chk("t2_sobe_arr", bus.sobe, 0);
        bus.shift = 1;
        tick();
        bus.shift = 0;
        chk("t2_vazia", bus.vazia, 1);
        chk("t2_tem_end", bus.tem_destino, 0);
        chk("t2_ocup_end", bus.ocupacao, 0);
        // invalid requests
        pedido(2, 2);
        chk("t3_rej_same", bus.pedido_rejeitado, 1);
        chk("t3_ocup_same", bus.ocupacao, 0);
        tick();
        chk("t3_rej_pulse", bus.pedido_rejeitado, 0);
        pedido(5, 0);
        chk("t3_rej_range", bus.pedido_rejeitado, 1);
        chk("t3_ocup_range", bus.ocupacao, 0);
        // fill the FIFO while the first entry starts serving
        bus.andar_atual = 0;
        pedido(1, 2);
        pedido(2, 3);
        pedido(3, 0);
        pedido(0, 1);
        chk("t4_cheia", bus.cheia, 1);
        chk("t4_ocup4", bus.ocupacao, 4);
        chk("t4_rej_ok", bus.pedido_rejeitado, 0);
        pedido(1, 3);
        chk("t4_rej_full", bus.pedido_rejeitado, 1);
        chk("t4_ocup_full", bus.ocupacao, 4);
        chk("t4_tem", bus.tem_destino, 1);
        chk("t4_dest_a", bus.destino_atual, 1);
        bus.shift = 1;
        tick();
        bus.shift = 0;
        tick();
        chk("t4_dest_leg", bus.destino_atual, 2);
        chk("t4_eh_leg", bus.eh_origem, 0);
        bus.shift = 1;
        pedido(2, 0);
        bus.shift = 0;
        chk("t4_push_pop_rej", bus.pedido_rejeitado, 0);
        chk("t4_push_pop_ocup", bus.ocupacao, 4);
        chk("t4_push_pop_tem", bus.tem_destino, 0);
        tick(); tick();
        chk("t4_next_head", bus.destino_atual, 2);
        chk("t4_next_eh", bus.eh_origem, 1);
        // limpar while serving with a full queue
        bus.limpar = 1;
        bus.shift = 1;
        tick();
        bus.limpar = 0;
        bus.shift = 0;
        chk("t6_clr_vazia", bus.vazia, 1);
        chk("t6_clr_ocup", bus.ocupacao, 0);
        chk("t6_clr_tem", bus.tem_destino, 0);
        chk("t6_clr_cheia", bus.cheia, 0);
        tick();
        chk("t6_clr_idle", bus.tem_destino, 0);
        // pickup on the current floor
        bus.andar_atual = 2;
        pedido(2, 0);
        tick(); tick();
        chk("t5_atende", bus.atende_local, 1);
        chk("t5_tem_load", bus.tem_destino, 0);
        tick();
        chk("t5_atende_end", bus.atende_local, 0);
        chk("t5_eh", bus.eh_origem, 0);
        chk("t5_dest", bus.destino_atual, 0);
        chk("t5_sobe", bus.sobe, 0);
        chk("t5_tem", bus.tem_destino, 1);
        bus.andar_atual = 0;
        bus.shift = 1;
        tick();
        bus.shift = 0;
        chk("t5_vazia", bus.vazia, 1);
        // delivery floor already reached when the destino leg loads
        pedido(1, 2);
        tick(); tick();
        chk("tl_tem", bus.tem_destino, 1);
        bus.andar_atual = 1;
        bus.shift = 1;
        tick();
        bus.shift = 0;
        bus.andar_atual = 2;
        tick();
        chk("tl_atende", bus.atende_local, 1);
        chk("tl_vazia", bus.vazia, 1);
        chk("tl_tem", bus.tem_destino, 0);
        // async reset in the middle of a leg
        pedido(0, 3);
        pedido(1, 3);
        pedido(3, 1);
        tick();
        chk("tr_tem", bus.tem_destino, 1);
        chk("tr_ocup", bus.ocupacao, 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("tr_vazia", bus.vazia, 1);
        chk("tr_ocup0", bus.ocupacao, 0);
        chk("tr_tem0", bus.tem_destino, 0);
        chk("tr_dest0", bus.destino_atual, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("tr_idle", bus.tem_destino, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
